rle_encoder: RTL and testbench



---
 rtl/jpeg_pkg.sv | 48 ++++
 rtl/ones_encoder.sv | 29 ++
 rtl/rle_encoder.sv | 158 +++++++++++++++
 tb/tb_rle_encoder.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared constants, symbol bundle and rle FSM states.
// No ports; imported by the rle encoder files.
package jpeg_pkg;

  localparam logic [3:0] RUN_ZRL   = 4'hF;
  localparam int         BLOCK_LEN = 64;
  localparam logic [5:0] K_LAST    = 6'(BLOCK_LEN - 1);
  localparam logic [5:0] ZRL_LEN   = 6'd16;

  typedef enum logic [1:0] {
    S_IN,
    S_ZRL,
    S_SYM,
    S_FLUSH
  } rle_state_t;

  typedef struct packed {
    logic        dc;
    logic [3:0]  run;
    logic [3:0]  size;
    logic [9:0]  val;
    logic [10:0] dc_val;
  } rle_sym_t;

  function automatic rle_sym_t dc_sym(
    input logic [10:0] v
  );
    rle_sym_t s;
    s        = '0;
    s.dc     = 1'b1;
    s.dc_val = v;
    return s;
  endfunction

  function automatic rle_sym_t ac_sym(
    input logic [3:0] r,
    input logic [3:0] sz,
    input logic [9:0] v
  );
    rle_sym_t s;
    s      = '0;
    s.run  = r;
    s.size = sz;
    s.val  = v;
    return s;
  endfunction

endpackage

// File: rtl/ones_encoder.sv
// ones_encoder: JPEG magnitude category and ones-complement bits.
// Ports: x (signed in), size (bit length of |x|), val (low size bits).
module ones_encoder #(
  parameter  int WIDTH = 11,
  localparam int SW    = $clog2(WIDTH + 1)
) (
  input  logic signed [WIDTH-1:0] x,
  output logic        [SW-1:0]    size,
  output logic        [WIDTH-2:0] val
);

  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] adj;

  always_comb begin
    mag  = x[WIDTH-1] ? WIDTH'(-x) : x;
    // negative values are sent as x-1, i.e. ones complement of |x|
    adj  = x[WIDTH-1] ? WIDTH'(x - 1'b1) : x;
    size = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mag[i]) size = SW'(i + 1);
    end
    val = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      val[i] = adj[i] && (i < int'(size));
    end
  end

endmodule

// File: rtl/rle_encoder.sv
// rle_encoder: zigzag 8x8 block in, JPEG DC/AC/ZRL/EOB symbols out.
// Ports: clk,rst; ena_in/rdy_out/in/last; ena_out/rdy_in/dc/out_dc/run/size/out; flush.
import jpeg_pkg::*;

module rle_encoder (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena_in,
  output logic               rdy_out,
  input  logic signed [10:0] in,
  input  logic               last,
  output logic               ena_out,
  input  logic               rdy_in,
  output logic               dc,
  output logic signed [10:0] out_dc,
  output logic [3:0]         run,
  output logic [3:0]         size,
  output logic [9:0]         out,
  output logic               flush
);

  rle_state_t         state_q, state_d;
  logic [5:0]         k_q, k_d;
  logic [5:0]         zrun_q, zrun_d;
  logic signed [10:0] hold_q, hold_d;
  logic               last_q, last_d;
  logic               pend_q, pend_d;
  rle_sym_t           sym_q, sym_d;

  logic               load;
  logic               accept;
  logic signed [10:0] src;
  logic signed [10:0] clamped;
  logic [3:0]         enc_size;
  logic [9:0]         enc_val;
  logic               k_first;
  logic               k_end;
  logic               zero;
  logic               long_run;

  assign rdy_out = (state_q == S_IN) && !pend_q;
  assign ena_out = pend_q && rdy_in;
  assign accept  = ena_in && rdy_out;

  assign src     = (state_q == S_SYM) ? hold_q : in;
  // -1024 is the only 11-bit code outside +-1023
  assign clamped = (src == 11'sh400) ? 11'sh401 : src;

  ones_encoder #(
    .WIDTH (11)
  ) u_ones (
    .x    (clamped),
    .size (enc_size),
    .val  (enc_val)
  );

  assign k_first  = (k_q == '0);
  assign k_end    = (k_q == K_LAST);
  assign zero     = (in == '0);
  assign long_run = (zrun_q >= ZRL_LEN);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    zrun_d  = zrun_q;
    hold_d  = hold_q;
    last_d  = last_q;
    sym_d   = sym_q;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      S_IN: begin
        if (accept) begin
          k_d = k_q + 6'd1;
          unique case (1'b1)
            k_first: begin
              load   = 1'b1;
              sym_d  = dc_sym(in);
              zrun_d = '0;
            end
            !k_first && zero && k_end: begin
              // trailing zeros collapse into EOB
              load   = 1'b1;
              sym_d  = ac_sym('0, '0, '0);
              zrun_d = '0;
              if (last) state_d = S_FLUSH;
            end
            !k_first && zero && !k_end: begin
              zrun_d = zrun_q + 6'd1;
            end
            !k_first && !zero && !long_run: begin
              load   = 1'b1;
              sym_d  = ac_sym(zrun_q[3:0], enc_size, enc_val);
              zrun_d = '0;
              if (k_end && last) state_d = S_FLUSH;
            end
            default: begin
              hold_d  = in;
              last_d  = k_end && last;
              state_d = S_ZRL;
            end
          endcase
        end
      end
      S_ZRL: begin
        if (!pend_q) begin
          load   = 1'b1;
          sym_d  = ac_sym(RUN_ZRL, '0, '0);
          zrun_d = zrun_q - ZRL_LEN;
          if (zrun_d < ZRL_LEN) state_d = S_SYM;
        end
      end
      S_SYM: begin
        if (!pend_q) begin
          load    = 1'b1;
          sym_d   = ac_sym(zrun_q[3:0], enc_size, enc_val);
          zrun_d  = '0;
          state_d = last_q ? S_FLUSH : S_IN;
        end
      end
      S_FLUSH: begin
        if (!pend_q) begin
          flush   = 1'b1;
          state_d = S_IN;
        end
      end
      default: state_d = S_IN;
    endcase
    pend_d = load || (pend_q && !ena_out);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IN;
      k_q     <= '0;
      zrun_q  <= '0;
      hold_q  <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      sym_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      zrun_q  <= zrun_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      sym_q   <= sym_d;
    end
  end

  assign dc     = sym_q.dc;
  assign out_dc = sym_q.dc_val;
  assign run    = sym_q.run;
  assign size   = sym_q.size;
  assign out    = sym_q.val;

endmodule

// File: tb/tb_rle_encoder.sv
// tb_rle_encoder: random and directed blocks checked against a
// symbol-list model of JPEG run-length coding.
module tb_rle_encoder;

  logic               clk    = 1'b0;
  logic               rst    = 1'b1;
  logic               ena_in = 1'b0;
  logic               rdy_out;
  logic signed [10:0] din    = '0;
  logic               last   = 1'b0;
  logic               ena_out;
  logic               rdy_in = 1'b1;
  logic               dc;
  logic signed [10:0] out_dc;
  logic [3:0]         run;
  logic [3:0]         size;
  logic [9:0]         dout;
  logic               flush;

  typedef struct {
    bit is_flush;
    bit dc;
    int dcv;
    int run;
    int size;
    int val;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   blk[64];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   last_ena  = 0;
  int   ena_cnt   = 0;
  int   flush_cnt = 0;
  int   rdy_mode  = 0;
  bit   chk_en    = 1'b0;

  rle_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .ena_in  (ena_in),
    .rdy_out (rdy_out),
    .in      (din),
    .last    (last),
    .ena_out (ena_out),
    .rdy_in  (rdy_in),
    .dc      (dc),
    .out_dc  (out_dc),
    .run     (run),
    .size    (size),
    .out     (dout),
    .flush   (flush)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rdy_in = 1'b1;
      1:       rdy_in = ($urandom_range(0, 3) != 0);
      default: rdy_in = 1'b0;
    endcase
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void push(bit f, bit d, int dv, int r, int s, int v);
    exp_t e;
    e.is_flush = f;
    e.dc       = d;
    e.dcv      = dv;
    e.run      = r;
    e.size     = s;
    e.val      = v;
    exp_q.push_back(e);
  endfunction

  function automatic void push_ac(int z, int x);
    int v = x;
    int m;
    int s = 0;
    if (v > 1023) v = 1023;
    if (v < -1023) v = -1023;
    m = (v < 0) ? -v : v;
    while (m > 0) begin
      m = m / 2;
      s++;
    end
    push(0, 0, 0, z, s, (v > 0) ? v : v + (1 << s) - 1);
  endfunction

  task automatic model_block(input bit l);
    int z = 0;
    push(0, 1, blk[0], 0, 0, 0);
    for (int i = 1; i < 64; i++) begin
      if (blk[i] == 0) begin
        if (i == 63) push(0, 0, 0, 0, 0, 0);
        else z++;
      end else begin
        while (z > 15) begin
          push(0, 0, 0, 15, 0, 0);
          z -= 16;
        end
        push_ac(z, blk[i]);
        z = 0;
      end
    end
    if (l) push(1, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  task automatic gen_block(input int dens);
    for (int i = 0; i < 64; i++) begin
      if (int'($urandom_range(0, 99)) < dens) begin
        if ($urandom_range(0, 1) == 0)
          blk[i] = int'($urandom_range(0, 2047)) - 1024;
        else
          blk[i] = int'($urandom_range(0, 16)) - 8;
      end else begin
        blk[i] = 0;
      end
    end
    blk[0] = int'($urandom_range(0, 2047)) - 1024;
  endtask

  task automatic put(input int c, input bit l);
    int t = 0;
    ena_in = 1'b1;
    din    = 11'(c);
    last   = l;
    while (!rdy_out && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) chk("accept_timeout", t, 0);
    @(posedge clk);
    #1;
    ena_in = 1'b0;
    last   = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_block(input bit l, input bit gaps);
    model_block(l);
    for (int i = 0; i < 64; i++) begin
      if (gaps && $urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      put(blk[i], l && (i == 63));
    end
    drain();
  endtask

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      if (ena_out || flush)
        chk("flush_with_ena", int'(ena_out && flush), 0);
      if (ena_out) begin
        ena_cnt++;
        last_ena = cyc;
        chk("sym_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("sym_not_flush", int'(cur.is_flush), 0);
          chk("dc", int'(dc), int'(cur.dc));
          if (cur.dc) chk("out_dc", int'(out_dc), cur.dcv);
          chk("run", int'(run), cur.run);
          chk("size", int'(size), cur.size);
          chk("out", int'(dout), cur.val);
        end
      end
      if (flush) begin
        flush_cnt++;
        chk("flush_gap", cyc - last_ena, 1);
        chk("flush_expected",
            (exp_q.size() > 0) ? int'(exp_q[0].is_flush) : 0, 1);
        if (exp_q.size() > 0 && exp_q[0].is_flush)
          void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int base;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_rdy_out", int'(rdy_out), 1);
    chk("rst_ena_out", int'(ena_out), 0);
    chk("rst_flush", int'(flush), 0);
    chk("rst_dc", int'(dc), 0);
    chk("rst_out_dc", int'(out_dc), 0);
    chk("rst_run", int'(run), 0);
    chk("rst_size", int'(size), 0);
    chk("rst_out", int'(dout), 0);

    clear_blk();
    blk[1] = 3;
    blk[2] = -3;
    model_block(0);
    chk("pinA_len", exp_q.size(), 4);
    chk("pinA_s1", exp_q[1].size, 2);
    chk("pinA_v1", exp_q[1].val, 3);
    chk("pinA_v2", exp_q[2].val, 0);
    chk("pinA_eob", exp_q[3].run + exp_q[3].size, 0);
    exp_q.delete();

    clear_blk();
    blk[63] = -1;
    model_block(0);
    chk("pinB_len", exp_q.size(), 5);
    chk("pinB_zrl", exp_q[3].run, 15);
    chk("pinB_run", exp_q[4].run, 14);
    chk("pinB_size", exp_q[4].size, 1);
    exp_q.delete();

    clear_blk();
    blk[21] = 7;
    model_block(0);
    chk("pinC_len", exp_q.size(), 4);
    chk("pinC_run", exp_q[2].run, 4);
    chk("pinC_val", exp_q[2].val, 7);
    exp_q.delete();

    clear_blk();
    blk[1] = -1024;
    blk[2] = 1023;
    blk[5] = -5;
    model_block(0);
    chk("pinD_size", exp_q[1].size, 10);
    chk("pinD_neg", exp_q[1].val, 0);
    chk("pinD_pos", exp_q[2].val, 1023);
    chk("pinD_m5", exp_q[3].val, 2);
    exp_q.delete();

    chk_en = 1'b1;

    clear_blk();
    blk[0] = -5;
    model_block(0);
    ena_cnt = 0;
    put(blk[0], 0);
    t0 = cyc;
    for (int i = 1; i < 64; i++) put(blk[i], 0);
    chk("zero_throughput", cyc - t0, 64);
    drain();
    chk("t1_pulses", ena_cnt, 2);

    rdy_mode = 1;
    clear_blk();
    blk[1] = 3;
    blk[2] = -3;
    send_block(0, 1);
    clear_blk();
    blk[21] = 7;
    send_block(0, 1);
    clear_blk();
    blk[63] = -1;
    send_block(0, 1);
    clear_blk();
    blk[1] = -1024;
    blk[2] = 1023;
    blk[5] = -5;
    send_block(0, 1);

    rdy_mode = 2;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    clear_blk();
    blk[0] = 100;
    blk[5] = -9;
    model_block(0);
    base = ena_cnt;
    put(blk[0], 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_rdy_out", int'(rdy_out), 0);
      chk("bp_ena_out", int'(ena_out), 0);
      chk("bp_dc", int'(dc), 1);
      chk("bp_out_dc", int'(out_dc), 100);
    end
    rdy_mode = 0;
    for (int i = 1; i < 64; i++) put(blk[i], 0);
    drain();
    chk("bp_issued", ena_cnt - base, 3);

    base = flush_cnt;
    clear_blk();
    blk[0] = 7;
    send_block(1, 0);
    chk("flush_eob", flush_cnt - base, 1);
    rdy_mode = 1;
    gen_block(20);
    base = flush_cnt;
    send_block(1, 1);
    chk("flush_rand", flush_cnt - base, 1);

    chk_en = 1'b0;
    gen_block(30);
    for (int i = 0; i < 30; i++) put(blk[i], 0);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_rdy", int'(rdy_out), 1);
    chk("mid_rst_ena", int'(ena_out), 0);
    chk("mid_rst_flush", int'(flush), 0);
    chk_en = 1'b1;
    gen_block(25);
    send_block(0, 1);

    for (int b = 0; b < 40; b++) begin
      case ($urandom_range(0, 3))
        0:       gen_block(3);
        1:       gen_block(15);
        2:       gen_block(40);
        default: gen_block(90);
      endcase
      rdy_mode = int'($urandom_range(0, 1));
      send_block($urandom_range(0, 4) == 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
